// File: rtl/chu_pad_arb.sv
// chu_pad_arb: round-robin sequencer sharing one chu_pad core among NREQ sources.
// Define CHU_PAD_ARB_PRIO_EN to give source 0 fixed top priority.
module chu_pad_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int ALGW = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_reset,
    input  logic [NREQ-1:0]      req_val,
    input  logic [NREQ-1:0]      req_sop,
    input  logic [NREQ-1:0]      req_eop,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ*ALGW-1:0] req_alg,
    output logic [NREQ-1:0]      req_rdy,
    input  logic                 pad_done,
    output logic                 pad_sop,
    output logic                 pad_val,
    output logic                 pad_eop,
    output logic [DW-1:0]        pad_data,
    output logic [ALGW-1:0]      pad_alg,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic [15:0]          msg_cnt,
    output logic                 proto_err
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_WAIT
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_rr;
    logic [IW-1:0]   r_idx;
    logic [NREQ-1:0] r_grant;
    logic            r_first;
    logic            r_pad_sop;
    logic            r_pad_val;
    logic            r_pad_eop;
    logic [DW-1:0]   r_pad_data;
    logic [ALGW-1:0] r_pad_alg;
    logic [15:0]     r_msg_cnt;
    logic            r_proto_err;

    logic [NREQ-1:0] w_cand;
    logic [NREQ-1:0] w_cand_rr;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_rr_nxt;
    logic            w_found;
    logic            w_upd_rr;
    logic            w_acc;
    logic            w_sop;
    logic            w_eop;
    logic [DW-1:0]   w_data;
    logic [ALGW-1:0] w_alg;

    assign w_cand = req_val & req_sop;

`ifdef CHU_PAD_ARB_PRIO_EN
    assign w_cand_rr = w_cand & ~NREQ'(1);
`else
    assign w_cand_rr = w_cand;
`endif

    // Lowest candidate overall, overridden by the lowest one at or after rr.
    always_comb begin
        w_win    = '0;
        w_found  = 1'b0;
        w_upd_rr = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_cand_rr[i]) begin
                w_win   = IW'(i);
                w_found = 1'b1;
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_cand_rr[i] && (IW'(i) >= r_rr)) begin
                w_win = IW'(i);
            end
        end
        w_upd_rr = w_found;
`ifdef CHU_PAD_ARB_PRIO_EN
        if (w_cand[0]) begin
            w_win    = '0;
            w_found  = 1'b1;
            w_upd_rr = 1'b0;
        end
`endif
    end

    assign w_rr_nxt = (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;

    assign req_rdy = (r_state == S_GRANT) ? r_grant : '0;
    assign w_acc   = |(req_val & req_rdy);
    assign w_sop   = req_sop[r_idx];
    assign w_eop   = req_eop[r_idx];
    assign w_data  = req_data[r_idx*DW +: DW];
    assign w_alg   = req_alg[r_idx*ALGW +: ALGW];

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            r_state     <= S_IDLE;
            r_rr        <= '0;
            r_idx       <= '0;
            r_grant     <= '0;
            r_first     <= 1'b0;
            r_pad_sop   <= 1'b0;
            r_pad_val   <= 1'b0;
            r_pad_eop   <= 1'b0;
            r_pad_data  <= '0;
            r_pad_alg   <= '0;
            r_msg_cnt   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_pad_val   <= 1'b0;
            r_pad_sop   <= 1'b0;
            r_pad_eop   <= 1'b0;
            r_proto_err <= pad_done && (r_state != S_WAIT);
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= NREQ'(1) << w_win;
                        r_idx   <= w_win;
                        r_first <= 1'b1;
                        r_state <= S_GRANT;
                        if (w_upd_rr) begin
                            r_rr <= w_rr_nxt;
                        end
                    end
                end
                S_GRANT: begin
                    if (w_acc) begin
                        r_pad_val  <= 1'b1;
                        r_pad_eop  <= w_eop;
                        r_pad_data <= w_data;
                        r_first    <= 1'b0;
                        // A sop inside a message is flagged and stripped.
                        if (r_first) begin
                            r_pad_sop <= w_sop;
                            r_pad_alg <= w_alg;
                            if (!w_sop) begin
                                r_proto_err <= 1'b1;
                            end
                        end else if (w_sop) begin
                            r_proto_err <= 1'b1;
                        end
                        if (w_eop) begin
                            r_grant   <= '0;
                            r_msg_cnt <= r_msg_cnt + 16'd1;
                            r_state   <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (pad_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pad_sop   = r_pad_sop;
    assign pad_val   = r_pad_val;
    assign pad_eop   = r_pad_eop;
    assign pad_data  = r_pad_data;
    assign pad_alg   = r_pad_alg;
    assign grant     = r_grant;
    assign busy      = (r_state != S_IDLE);
    assign msg_cnt   = r_msg_cnt;
    assign proto_err = r_proto_err;

endmodule
